// File: rtl/rv32_register_file_if.sv
// Register file access bus: write-back request in, two combinational read ports out.
interface rv32_register_file_if #(
    parameter int unsigned XLEN = 32
);
    logic            reg_wr_en;
    logic [31:0]     instruction;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] rd_data1;
    logic [XLEN-1:0] rd_data2;

    // Datapath side: supplies the instruction word and write-back data.
    modport master (
        output reg_wr_en,
        output instruction,
        output wr_data,
        input  rd_data1,
        input  rd_data2
    );

    // Register file side.
    modport slave (
        input  reg_wr_en,
        input  instruction,
        input  wr_data,
        output rd_data1,
        output rd_data2
    );
endinterface

// File: rtl/rv32_register_file.sv
// RV32I integer register file: rs1/rs2/rd decoded from the raw instruction,
// two zero-latency read ports, one synchronous write port, x0 hardwired to 0.
module rv32_register_file #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32_register_file_if.slave  bus
);
    localparam int unsigned IDX_W = 5;

    logic [IDX_W-1:0] rs1;
    logic [IDX_W-1:0] rs2;
    logic [IDX_W-1:0] rd;
    logic             unused_instr_bits;

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];

    // Register index decode; fixed fields regardless of opcode.
    always_comb begin
        rs1 = bus.instruction[19:15];
        rs2 = bus.instruction[24:20];
        rd  = bus.instruction[11:7];
    end

    assign unused_instr_bits = ^{bus.instruction[31:25], bus.instruction[14:12],
                                 bus.instruction[6:0]};

    // Next register contents: single write port, writes to x0 discarded.
    always_comb begin
        regs_d = regs_q;
        if (bus.reg_wr_en && (rd != '0)) begin
            regs_d[rd] = bus.wr_data;
        end
    end

    // Register storage; reset clears everything and overrides a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports without write bypass; index 0 always reads zero.
    always_comb begin
        bus.rd_data1 = (rs1 == '0) ? '0 : regs_q[rs1];
        bus.rd_data2 = (rs2 == '0) ? '0 : regs_q[rs2];
    end
endmodule

// File: tb/tb_rv32_register_file.sv
// Bench for rv32_register_file: directed sequence followed by random traffic,
// checked through an expectation queue drained by an independent monitor.
module tb_rv32_register_file;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    rv32_register_file_if #(.XLEN(32)) bus ();

    rv32_register_file #(
        .XLEN     (32),
        .NUM_REGS (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t        exp_q[$];
    int          tests  = 0;
    int          failed = 0;
    logic [31:0] model [32];
    bit          model_known = 1'b0;
    bit          stim_done   = 1'b0;

    function automatic logic [31:0] mk_instr(input int unsigned r1, input int unsigned r2,
                                              input int unsigned rdi);
        logic [31:0] w;
        w = 32'h0000_0033;
        w[19:15] = r1[4:0];
        w[24:20] = r2[4:0];
        w[11:7]  = rdi[4:0];
        return w;
    endfunction

    function automatic logic [31:0] model_read(input int unsigned idx);
        if (idx == 0) return 32'h0;
        return model[idx];
    endfunction

    // One cycle: drive inputs, queue what the reads must show before the edge,
    // then advance the reference model across the edge.
    task automatic step(input string name, input logic r, input logic we,
                        input logic [31:0] instr, input logic [31:0] data);
        exp_t e;
        int unsigned rs1_i, rs2_i, rd_i;
        rst             = r;
        bus.reg_wr_en   = we;
        bus.instruction = instr;
        bus.wr_data     = data;
        rs1_i = int'(instr[19:15]);
        rs2_i = int'(instr[24:20]);
        rd_i  = int'(instr[11:7]);
        if (model_known) begin
            e.name = name;
            e.e1   = model_read(rs1_i);
            e.e2   = model_read(rs2_i);
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            model_known = 1'b1;
        end else if (we && rd_i != 0) begin
            model[rd_i] = data;
        end
        #1;
    endtask

    // Monitor: outputs are settled by the falling edge; compare against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (bus.rd_data1 !== e.e1) begin
                    failed++;
                    $display("FAIL %s rd_data1: got %h expected %h", e.name, bus.rd_data1, e.e1);
                end
                tests++;
                if (bus.rd_data2 !== e.e2) begin
                    failed++;
                    $display("FAIL %s rd_data2: got %h expected %h", e.name, bus.rd_data2, e.e2);
                end
            end
        end
    end

    initial begin
        bus.reg_wr_en   = 1'b0;
        bus.instruction = 32'h0;
        bus.wr_data     = 32'h0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(posedge clk);
        #1;

        // Directed sequence
        step("reset",        1'b1, 1'b0, 32'h0000_0000, 32'h0);
        step("post_reset",   1'b0, 1'b0, 32'h0149_8933, 32'h0);
        step("write_x18",    1'b0, 1'b1, 32'h0149_8933, 32'd42);
        step("readback_x18", 1'b0, 1'b0, 32'h0009_0033, 32'h0);
        step("x0_write",     1'b0, 1'b1, 32'h0000_0033, 32'hDEAD_BEEF);
        step("x0_read",      1'b0, 1'b0, 32'h0000_0033, 32'h0);
        step("en_low",       1'b0, 1'b0, mk_instr(18, 0, 18), 32'd7);
        step("x18_kept",     1'b0, 1'b0, mk_instr(18, 18, 0), 32'h0);
        step("rst_priority", 1'b1, 1'b1, mk_instr(5, 18, 5), 32'd9);
        step("after_rst",    1'b0, 1'b0, mk_instr(5, 18, 0), 32'h0);
        step("write_x3",     1'b0, 1'b1, mk_instr(0, 0, 3), 32'h1234_5678);
        step("write_x4",     1'b0, 1'b1, mk_instr(0, 0, 4), 32'hCAFE_F00D);
        step("dual_port",    1'b0, 1'b0, mk_instr(3, 4, 0), 32'h0);
        step("no_bypass",    1'b0, 1'b1, mk_instr(3, 4, 3), 32'd1);
        step("after_write",  1'b0, 1'b0, mk_instr(3, 3, 0), 32'h0);
        step("x31_write",    1'b0, 1'b1, mk_instr(0, 0, 31), 32'hFFFF_FFFF);
        step("x31_read",     1'b0, 1'b0, mk_instr(31, 1, 0), 32'h0);

        // Random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic        we;
            logic [31:0] instr;
            logic [31:0] data;
            r     = ($urandom_range(0, 31) == 0);
            we    = ($urandom_range(0, 3) != 0);
            instr = $urandom;
            data  = $urandom;
            step("random", r, we, instr, data);
        end
        step("final_read", 1'b0, 1'b0, $urandom, 32'h0);
        stim_done = 1'b1;

        // Let the monitor drain, bounded
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/rv32_register_file.md
Name: rv32_register_file

Overview:
- RV32I integer register file for the single-cycle core datapath; sits between instruction fetch/decode and the ALU.
- Extracts rs1/rs2/rd from the raw 32-bit instruction word and provides two combinational read ports.
- Provides one synchronous write port for writeback data; x0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register and of the data ports.
- NUM_REGS, 32, number of architectural registers; index width is 5 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- reg_wr_en  input  1  write enable for the rd register.
- instruction  input  32  current instruction word; register indices are decoded from it.
- wr_data  input  XLEN  writeback data for rd.
- rd_data1  output  XLEN  contents of register rs1.
- rd_data2  output  XLEN  contents of register rs2.

Behaviour:
- Index decode, combinational, independent of opcode:
  - rs1 = instruction[19:15]
  - rs2 = instruction[24:20]
  - rd = instruction[11:7]
  - Other instruction bits are ignored.
- Storage: 32 x XLEN registers, x0..x31.
- Reset:
  - On a rising clk edge with rst=1, all registers clear to 0.
  - Reset has priority over any write in the same cycle.
  - rd_data1/rd_data2 read 0 from the cycle after the reset edge.
  - Register contents before the first reset edge are undefined.
- Write:
  - On a rising clk edge with rst=0 and reg_wr_en=1 and rd!=0, register[rd] <= wr_data.
  - No write occurs when reg_wr_en=0.
- x0:
  - Writes with rd=0 are discarded.
  - Reads with rs1=0 or rs2=0 always return 0.
- Read:
  - Purely combinational, zero latency: rd_data1 = reg[rs1], rd_data2 = reg[rs2].
  - Outputs change immediately when instruction changes.
- No internal bypass on same-cycle read/write:
  - If rs1 or rs2 equals the rd being written, the output shows the old value until the clock edge.
  - The new value appears just after the edge.
- rs1 == rs2: both outputs carry the same value.
- Synchronous reset, writes and reads all work for any register index 0..31; there is no out-of-range case.
- Reset asserted mid-operation (while reg_wr_en=1): the pending write is dropped and all registers clear.
- Outputs never go X once the first reset has been applied.

Test Plan:
- Reset:
  - Stimulus: rst=1 for one rising edge, instruction=0, wr_data=0.
  - Response: afterwards, rd_data1=rd_data2=0 for any rs1/rs2, e.g. instruction 0x01498933 reads x19 and x20.
- Basic write:
  - Stimulus: rst=0, reg_wr_en=1, instruction=0x01498933 (add x18,x19,x20), wr_data=42, one rising edge.
  - Response: x18=42. Before the edge, rd_data1=rd_data2=0 (x19, x20 unaffected).
- Readback:
  - Stimulus: reg_wr_en=0, instruction=0x00090033 (rs1=18).
  - Response: rd_data1=42, rd_data2=0 combinationally, with no clock needed.
- x0 protection:
  - Stimulus: reg_wr_en=1, instruction=0x00000033 (rd=0), wr_data=0xDEADBEEF, one edge.
  - Response: reading rs1=0 returns 0.
- Enable low and reset priority:
  - Stimulus: reg_wr_en=0, rd=18, wr_data=7, one edge.
  - Response: x18 stays 42.
  - Stimulus: then rst=1 and reg_wr_en=1, rd=5, wr_data=9, one edge.
  - Response: x5=0 and x18=0.
- Same-cycle read/write and dual port:
  - Stimulus: write x3=0x12345678, x4=0xCAFEF00D, then instruction with rs1=3, rs2=4.
  - Response: rd_data1=0x12345678, rd_data2=0xCAFEF00D.
  - Stimulus: then rs1=rd=3, reg_wr_en=1, wr_data=1.
  - Response: rd_data1 holds 0x12345678 before the edge and reads 1 after it.
